// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ctrl_pkg
// Brief   : Shared state encoding for the FIFO occupancy controller.
// Revision: 1.0
// ============================================================================
package fifo_ctrl_pkg;

  localparam int c_state_w = 2;

  typedef logic [c_state_w-1:0] fifo_state_enc_t;

  typedef enum fifo_state_enc_t {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_cnt.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ptr_cnt
// Brief   : Wrapping address pointer; wraps after DEPTH-1 so non-power-of-2
//           depths are supported.
// Revision: 1.0
// ============================================================================
module fifo_ptr_cnt #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] pointer
);

  localparam logic [WIDTH-1:0] c_ptr_last = WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (enable) begin
      ptr_d = (ptr_q == c_ptr_last) ? '0 : ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign pointer = ptr_q;

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ctrl
// Brief   : FIFO occupancy controller: pointers, count, flags, error pulses.
//           Optional almost_full/almost_empty outputs when FIFO_CTRL_ALMOST_EN
//           is defined.
// Revision: 1.0
// ============================================================================
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MEMORY_DEPTH      = 4,
  parameter int FIFO_ADDRESS_SIZE = 2
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  parameter int ALMOST_LEVEL      = 1
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req,
  input  logic                         rd_req,
  output logic                         wr_en,
  output logic                         rd_en,
  output logic [FIFO_ADDRESS_SIZE-1:0] w_ptr,
  output logic [FIFO_ADDRESS_SIZE-1:0] r_ptr,
  output logic [FIFO_ADDRESS_SIZE:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  output logic                         almost_full,
  output logic                         almost_empty
`endif
);

  localparam int c_cnt_w = FIFO_ADDRESS_SIZE + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEMORY_DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  fifo_state_e        state_q;
  logic [c_cnt_w-1:0] count_q;
  logic [c_cnt_w-1:0] count_d;
  logic               full_q;
  logic               empty_q;
  logic               overflow_q;
  logic               underflow_q;
  logic               w_wr_en;
  logic               w_rd_en;

  // Strobes are masked by reset so no pointer moves while rst is high.
  assign w_wr_en = wr_req & ~full_q  & ~rst;
  assign w_rd_en = rd_req & ~empty_q & ~rst;

  always_comb begin
    count_d = count_q;
    case ({w_wr_en, w_rd_en})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= wr_req & full_q;
      underflow_q <= rd_req & empty_q;
      case (state_q)
        EMPTY: begin
          if (w_wr_en) begin
            state_q <= PARTIAL;
            empty_q <= 1'b0;
          end
        end
        PARTIAL: begin
          if (w_wr_en && !w_rd_en && (count_q == c_cnt_last)) begin
            state_q <= FULL;
            full_q  <= 1'b1;
          end else if (w_rd_en && !w_wr_en && (count_q == c_cnt_one)) begin
            state_q <= EMPTY;
            empty_q <= 1'b1;
          end
        end
        FULL: begin
          if (w_rd_en) begin
            state_q <= PARTIAL;
            full_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= EMPTY;
          full_q  <= 1'b0;
          empty_q <= 1'b1;
        end
      endcase
    end
  end

  fifo_ptr_cnt #(
    .DEPTH (MEMORY_DEPTH),
    .WIDTH (FIFO_ADDRESS_SIZE)
  ) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .enable  (w_wr_en),
    .pointer (w_ptr)
  );

  fifo_ptr_cnt #(
    .DEPTH (MEMORY_DEPTH),
    .WIDTH (FIFO_ADDRESS_SIZE)
  ) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .enable  (w_rd_en),
    .pointer (r_ptr)
  );

`ifdef FIFO_CTRL_ALMOST_EN
  logic almost_full_q;
  logic almost_empty_q;

  // Thresholds use next-state count so the flags line up with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (int'(count_d) >= (MEMORY_DEPTH - ALMOST_LEVEL));
      almost_empty_q <= (int'(count_d) <= ALMOST_LEVEL);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

  assign wr_en     = w_wr_en;
  assign rd_en     = w_rd_en;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_ctrl
// Brief   : Scoreboard bench for fifo_ctrl (depth 4); honours FIFO_CTRL_ALMOST_EN.
// Revision: 1.0
// ============================================================================
module tb_fifo_ctrl;

  localparam int D  = 4;
  localparam int AW = 2;
  localparam int AL = 1;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] w_ptr;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_CTRL_ALMOST_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  fifo_ctrl #(
    .MEMORY_DEPTH      (D),
    .FIFO_ADDRESS_SIZE (AW)
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    .ALMOST_LEVEL      (AL)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .w_ptr        (w_ptr),
    .r_ptr        (r_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int wr_en;
    int rd_en;
    int w_ptr;
    int r_ptr;
    int count;
    int full;
    int empty;
    int ovf;
    int udf;
    int af;
    int ae;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: occupancy and pointers as plain integers.
  int m_occ, m_wp, m_rp, m_ovf, m_udf, m_af, m_ae;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_occ = 0; m_wp = 0; m_rp = 0;
    m_ovf = 0; m_udf = 0;
    m_af  = (0 >= D - AL) ? 1 : 0;
    m_ae  = 1;
  endtask

  task automatic step(input bit wr, input bit rd, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    wr_req = wr;
    rd_req = rd;
    rst    = r;
    e.wr_en = (!r && wr && m_occ < D) ? 1 : 0;
    e.rd_en = (!r && rd && m_occ > 0) ? 1 : 0;
    e.w_ptr = m_wp;
    e.r_ptr = m_rp;
    e.count = m_occ;
    e.full  = (m_occ == D) ? 1 : 0;
    e.empty = (m_occ == 0) ? 1 : 0;
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    e.af    = m_af;
    e.ae    = m_ae;
    sb_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      m_ovf = (wr && m_occ == D) ? 1 : 0;
      m_udf = (rd && m_occ == 0) ? 1 : 0;
      if (e.wr_en == 1) begin
        m_wp  = (m_wp + 1) % D;
        m_occ = m_occ + 1;
      end
      if (e.rd_en == 1) begin
        m_rp  = (m_rp + 1) % D;
        m_occ = m_occ - 1;
      end
      m_af = (m_occ >= D - AL) ? 1 : 0;
      m_ae = (m_occ <= AL) ? 1 : 0;
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("wr_en",     int'(wr_en),     e.wr_en);
        chk("rd_en",     int'(rd_en),     e.rd_en);
        chk("w_ptr",     int'(w_ptr),     e.w_ptr);
        chk("r_ptr",     int'(r_ptr),     e.r_ptr);
        chk("count",     int'(count),     e.count);
        chk("full",      int'(full),      e.full);
        chk("empty",     int'(empty),     e.empty);
        chk("overflow",  int'(overflow),  e.ovf);
        chk("underflow", int'(underflow), e.udf);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("almost_full",  int'(almost_full),  e.af);
        chk("almost_empty", int'(almost_empty), e.ae);
`endif
      end
    end
  end

  initial begin
    int pw;
    int pr;
    bit w;
    bit rr;
    bit rs;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held with both requests: strobes must stay low.
    step(1, 1, 1);
    // Fill to full, then overflow attempt.
    repeat (4) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    // Full with both requests: only the read goes through.
    step(1, 1, 0);
    step(0, 0, 0);
    // Reset at count 3 while writing.
    step(1, 0, 1);
    step(0, 0, 0);
    // Underflow from empty.
    step(0, 1, 0);
    step(0, 0, 0);
    // Count 2, six simultaneous read/write cycles with wrap.
    repeat (2) step(1, 0, 0);
    repeat (6) step(1, 1, 0);
    step(0, 0, 0);
    // Drain, then empty with both requests.
    repeat (3) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);

    // Random phase with biased blocks so full and empty are both visited.
    for (int blk = 0; blk < 64; blk++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 32; i++) begin
        w  = ($urandom_range(0, 99) < pw);
        rr = ($urandom_range(0, 99) < pr);
        rs = ($urandom_range(0, 149) == 0);
        step(w, rr, rs);
      end
    end

    @(posedge clk);
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
